// File: rtl/clk_event_gen_multi_if.sv
// Per-channel configuration and event bundle for clk_event_gen_multi.
// master drives the configuration; slave (the generator) drives clocks and events.
interface clk_event_gen_multi_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned COUNT_W  = 16
);
    logic [CHANNELS-1:0]              enable;
    logic [CHANNELS-1:0]              idle_high;
    logic [CHANNELS-1:0][COUNT_W-1:0] half_period;
    logic [CHANNELS-1:0][COUNT_W-1:0] stable_point;
    logic [CHANNELS-1:0]              io_clk;
    logic [CHANNELS-1:0]              active;
    logic [CHANNELS-1:0]              rising_edge;
    logic [CHANNELS-1:0]              falling_edge;
    logic [CHANNELS-1:0]              stable_high;
    logic [CHANNELS-1:0]              stable_low;

    modport master (
        output enable, idle_high, half_period, stable_point,
        input  io_clk, active, rising_edge, falling_edge, stable_high, stable_low
    );

    modport slave (
        input  enable, idle_high, half_period, stable_point,
        output io_clk, active, rising_edge, falling_edge, stable_high, stable_low
    );
endinterface

// File: rtl/clk_event_gen_multi.sv
// Multi-channel IO clock generator: per-channel half-period counter producing the
// clock plus rising/falling/stable event strobes, with graceful stop at period end.
module clk_event_gen_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_event_gen_multi_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    genvar ch;
    for (ch = 0; ch < int'(CHANNELS); ch++) begin : g_ch
        state_t             state_q, state_d;
        logic [COUNT_W-1:0] cnt_q, cnt_d;
        logic [COUNT_W-1:0] hp_q, hp_d;
        logic [COUNT_W-1:0] sp_q, sp_d;
        logic [COUNT_W-1:0] hp_eff;
        logic               idle_q, idle_d;
        logic               io_q, io_d;
        logic               act_q, act_d;
        logic               rise_q, rise_d;
        logic               fall_q, fall_d;
        logic               sh_q, sh_d;
        logic               sl_q, sl_d;

        assign hp_eff = (hp_q == '0) ? COUNT_W'(1) : hp_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hp_q    <= '0;
                sp_q    <= '0;
                idle_q  <= 1'b0;
                io_q    <= 1'b0;
                act_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                sh_q    <= 1'b0;
                sl_q    <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hp_q    <= hp_d;
                sp_q    <= sp_d;
                idle_q  <= idle_d;
                io_q    <= io_d;
                act_q   <= act_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                sh_q    <= sh_d;
                sl_q    <= sl_d;
            end
        end

        // Events are decoded from the next-cycle counter/level so they line up
        // with the registered io_clk they describe.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hp_d    = hp_q;
            sp_d    = sp_q;
            idle_d  = idle_q;
            io_d    = io_q;
            act_d   = act_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            sh_d    = 1'b0;
            sl_d    = 1'b0;
            unique case (state_q)
                IDLE: begin
                    io_d  = bus.idle_high[ch];
                    act_d = 1'b0;
                    if (bus.enable[ch]) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        hp_d    = bus.half_period[ch];
                        sp_d    = bus.stable_point[ch];
                        idle_d  = bus.idle_high[ch];
                        act_d   = 1'b1;
                        if (bus.stable_point[ch] == '0) begin
                            sh_d = io_d;
                            sl_d = ~io_d;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q == hp_eff - COUNT_W'(1)) begin
                        cnt_d  = '0;
                        io_d   = ~io_q;
                        rise_d = io_d;
                        fall_d = ~io_d;
                        // Returning to idle level closes a full period: reload config, maybe stop.
                        if (io_d == idle_q) begin
                            hp_d = bus.half_period[ch];
                            sp_d = bus.stable_point[ch];
                            if (!bus.enable[ch]) begin
                                state_d = IDLE;
                                act_d   = 1'b0;
                            end
                        end
                        if (state_d == RUN && sp_d == '0) begin
                            sh_d = io_d;
                            sl_d = ~io_d;
                        end
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                        if (cnt_d == sp_q) begin
                            sh_d = io_q;
                            sl_d = ~io_q;
                        end
                    end
                end
            endcase
        end

        assign bus.io_clk[ch]       = io_q;
        assign bus.active[ch]       = act_q;
        assign bus.rising_edge[ch]  = rise_q;
        assign bus.falling_edge[ch] = fall_q;
        assign bus.stable_high[ch]  = sh_q;
        assign bus.stable_low[ch]   = sl_q;
    end
endmodule
